if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: width of PC, address and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port Stall_i, input, 1: downstream hold; the delivered instruction is not consumed.
REQ-006 SHALL have port Flush_i, input, 1: control-flow redirect request.
REQ-007 SHALL have port BranchTarget_i, input, DATA_LEN: redirect PC.
REQ-008 SHALL have port imem_req_o, output, 1: instruction memory request valid.
REQ-009 SHALL have port imem_addr_o, output, DATA_LEN: request address.
REQ-010 SHALL have port imem_ready_i, input, 1: memory accepts the request this cycle.
REQ-011 SHALL have port imem_valid_i, input, 1: response data valid this cycle.
REQ-012 SHALL have port imem_data_i, input, DATA_LEN: response instruction word.
REQ-013 SHALL have port PC_o, output, DATA_LEN: PC of the current fetch/delivered instruction (feeds the IF/ID register).
REQ-014 SHALL have port inst_o, output, DATA_LEN: delivered instruction, or NOP 32'h0000_0033 when not valid.
REQ-015 SHALL have port inst_valid_o, output, 1: inst_o holds a real fetched instruction.
REQ-016 SHALL have port fetch_busy_o, output, 1: high whenever inst_valid_o is low (front-end stall indication).

Function
REQ-017 SHALL implement FSM states FETCH, WAIT, READY, a PC register pc, a squash flag and an instruction register inst_r.
REQ-018 SHALL keep at most one memory request outstanding.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=pc; on imem_ready_i=1 SHALL go to WAIT; otherwise stay in FETCH.
REQ-020 WAIT: imem_req_o=0; on imem_valid_i=1 with squash=0, SHALL load inst_r<=imem_data_i and go to READY.
REQ-021 WAIT: on imem_valid_i=1 with squash=1, SHALL discard the data, clear squash and go to FETCH.
REQ-022 READY: inst_valid_o=1, inst_o=inst_r; with Stall_i=0 and Flush_i=0, SHALL set pc<=pc+4 and go to FETCH (instruction consumed at that edge).
REQ-023 READY with Stall_i=1 and Flush_i=0 SHALL hold state, pc and inst_r unchanged for any number of cycles.
REQ-024 Flush_i=1 SHALL take priority over Stall_i in every state and SHALL set pc<=BranchTarget_i with bits [1:0] forced to 0.
REQ-025 Flush_i in READY SHALL drop the held instruction and go to FETCH.
REQ-026 Flush_i in FETCH with imem_ready_i=0 SHALL stay in FETCH; the new pc appears on imem_addr_o the next cycle.
REQ-027 Flush_i in FETCH with imem_ready_i=1 SHALL go to WAIT with squash<=1.
REQ-028 Flush_i in WAIT with imem_valid_i=0 SHALL set squash<=1 and stay in WAIT.
REQ-029 Flush_i in WAIT with imem_valid_i=1 SHALL discard the data and go to FETCH with squash<=0.
REQ-030 pc+4 SHALL wrap modulo 2^DATA_LEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 imem_valid_i in FETCH or READY SHALL be ignored.
REQ-032 PC_o SHALL equal pc in all states; inst_o and inst_valid_o SHALL be driven from registered state only (no combinational path from imem_* inputs).

Reset
REQ-033 When rst_i=0, the block SHALL asynchronously set state=FETCH, pc=RESET_PC, squash=0 and inst_r=32'h0000_0033.
REQ-034 During reset, outputs SHALL read imem_req_o=1, imem_addr_o=RESET_PC, inst_valid_o=0 and fetch_busy_o=1.
REQ-035 Reset asserted mid-WAIT or mid-READY SHALL abandon the transaction; the memory is reset alongside this block.

Verification
REQ-036 Reset release with imem_ready_i=1 and a 1-cycle-latency memory -> addresses 0x0, 0x4, 0x8 issued in order; inst_valid_o pulses with matching PC_o and data.
REQ-037 READY with Stall_i=1 for 5 cycles at pc=0x10 -> inst_o and PC_o stable and no request issued; on release -> next request to 0x14.
REQ-038 Flush_i with BranchTarget_i=0x103 in WAIT, response 2 cycles later -> response discarded, next request to 0x100, inst_valid_o never high for the old PC.
REQ-039 Flush_i and imem_valid_i in the same WAIT cycle with target 0x200 -> data dropped, FETCH at 0x200 next cycle.
REQ-040 Flush_i and Stall_i both high in READY with target 0x40 -> redirect wins; next request to 0x40.
REQ-041 pc=0xFFFF_FFFC consumed -> next request to 0x0000_0000; rst_i pulsed low mid-WAIT -> immediate FETCH at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: a single-outstanding-request fetch FSM with PC
// redirect (flush), downstream stall hold and squash of in-flight responses.
module if_fetch_unit #(
  parameter int unsigned             DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0]     RESET_PC = DATA_LEN'(32'h0000_0000)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                Stall_i,
  input  logic                Flush_i,
  input  logic [DATA_LEN-1:0] BranchTarget_i,
  output logic                imem_req_o,
  output logic [DATA_LEN-1:0] imem_addr_o,
  input  logic                imem_ready_i,
  input  logic                imem_valid_i,
  input  logic [DATA_LEN-1:0] imem_data_i,
  output logic [DATA_LEN-1:0] PC_o,
  output logic [DATA_LEN-1:0] inst_o,
  output logic                inst_valid_o,
  output logic                fetch_busy_o
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  localparam logic [DATA_LEN-1:0] NOP = DATA_LEN'(32'h0000_0033);

  logic [1:0]          state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic                squash_q, squash_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic [DATA_LEN-1:0] flush_pc;

  // Redirect targets are word aligned; the low two bits are masked off.
  assign flush_pc = BranchTarget_i & ~DATA_LEN'(3);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    inst_d   = inst_q;
    case (state_q)
      FETCH: begin
        // A request accepted in the same cycle as a flush is for the old PC,
        // so its response must be dropped.
        if (imem_ready_i) begin
          state_d  = WAIT;
          squash_d = Flush_i;
        end
        if (Flush_i) pc_d = flush_pc;
      end
      WAIT: begin
        if (imem_valid_i) begin
          squash_d = 1'b0;
          if (Flush_i || squash_q) begin
            state_d = FETCH;
          end else begin
            state_d = READY;
            inst_d  = imem_data_i;
          end
        end else if (Flush_i) begin
          squash_d = 1'b1;
        end
        if (Flush_i) pc_d = flush_pc;
      end
      READY: begin
        if (Flush_i) begin
          pc_d    = flush_pc;
          state_d = FETCH;
        end else if (!Stall_i) begin
          pc_d    = pc_q + DATA_LEN'(4);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      inst_q   <= NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      inst_q   <= inst_d;
    end
  end

  assign imem_req_o   = (state_q == FETCH);
  assign imem_addr_o  = pc_q;
  assign PC_o         = pc_q;
  assign inst_valid_o = (state_q == READY);
  assign inst_o       = inst_valid_o ? inst_q : NOP;
  assign fetch_busy_o = ~inst_valid_o;

endmodule
